// File: rtl/secuenciador_rtc.sv
// secuenciador_rtc: sequences RTC bus accesses over the ten local
// time/date/timer registers (read sweep 0..9 or group write-back).
// Drives the local register index, the active-low hold-register load
// strobe and the write data mux, and hands each access to the byte
// engine through the tr_inicio / tr_listo handshake.
// Optional build macro: SEQ_TIMEOUT_EN (ESPERA timeout with ABORTA state).
module secuenciador_rtc #(
    parameter int TIMEOUT_CICLOS = 2000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       inicio_lectura,
    input  logic       inicio_escritura,
    input  logic [2:0] funcion_conf,
    input  logic [7:0] seg_hora,
    input  logic [7:0] min_hora,
    input  logic [7:0] hora_hora,
    input  logic [7:0] dia_fecha,
    input  logic [7:0] mes_fecha,
    input  logic [7:0] jahr_fecha,
    input  logic [7:0] dia_semana,
    input  logic [7:0] seg_timer,
    input  logic [7:0] min_timer,
    input  logic [7:0] hora_timer,
    input  logic       tr_listo,
    output logic       tr_inicio,
    output logic       tr_escribe,
    output logic [7:0] dir_rtc,
    output logic [7:0] dato_escritura,
    output logic [3:0] addr_mem_local,
    output logic       reg_rd,
    output logic       ocupado,
    output logic       fin,
    output logic       error_tiempo
);

    localparam logic [2:0] REPOSO    = 3'd0;
    localparam logic [2:0] CARGA     = 3'd1;
    localparam logic [2:0] SOLICITA  = 3'd2;
    localparam logic [2:0] ESPERA    = 3'd3;
    localparam logic [2:0] CAPTURA   = 3'd4;
    localparam logic [2:0] SIGUIENTE = 3'd5;
    localparam logic [2:0] FIN       = 3'd6;
`ifdef SEQ_TIMEOUT_EN
    localparam logic [2:0] ABORTA    = 3'd7;
    localparam logic [11:0] LIMITE   = 12'(TIMEOUT_CICLOS - 1);
`endif

    // Sequencer state: current index, last index of the latched range,
    // and direction of the whole sequence.
    logic [2:0] estado_q, estado_d;
    logic [3:0] idx_q, idx_d;
    logic [3:0] ultima_q, ultima_d;
    logic       escribe_q, escribe_d;

    // Registered outputs.
    logic       tr_inicio_q;
    logic       tr_escribe_q;
    logic [7:0] dir_rtc_q;
    logic [7:0] dato_q;
    logic [3:0] addr_q;
    logic       reg_rd_q;
    logic       ocupado_q;
    logic       fin_q;

    logic       en_secuencia_d;
    logic [7:0] dir_sel;
    logic [7:0] dato_sel;

`ifdef SEQ_TIMEOUT_EN
    logic [11:0] cnt_q, cnt_d;
    logic        error_q;
`endif

    // Next-state logic of the access sequencer.
    always_comb begin
        estado_d  = estado_q;
        idx_d     = idx_q;
        ultima_d  = ultima_q;
        escribe_d = escribe_q;
        case (estado_q)
            REPOSO: begin
                // Write request takes priority over a simultaneous read.
                if (inicio_escritura) begin
                    escribe_d = 1'b1;
                    case (funcion_conf)
                        3'b001: begin
                            idx_d    = 4'd0;
                            ultima_d = 4'd2;
                            estado_d = CARGA;
                        end
                        3'b010: begin
                            idx_d    = 4'd3;
                            ultima_d = 4'd6;
                            estado_d = CARGA;
                        end
                        3'b100: begin
                            idx_d    = 4'd7;
                            ultima_d = 4'd9;
                            estado_d = CARGA;
                        end
                        default: estado_d = FIN;
                    endcase
                end else if (inicio_lectura) begin
                    escribe_d = 1'b0;
                    idx_d     = 4'd0;
                    ultima_d  = 4'd9;
                    estado_d  = CARGA;
                end
            end
            CARGA:    estado_d = SOLICITA;
            SOLICITA: estado_d = ESPERA;
            ESPERA: begin
                if (tr_listo) begin
                    estado_d = CAPTURA;
                end
`ifdef SEQ_TIMEOUT_EN
                else if (cnt_q == LIMITE) begin
                    estado_d = ABORTA;
                end
`endif
            end
            CAPTURA: estado_d = SIGUIENTE;
            SIGUIENTE: begin
                if (idx_q < ultima_q) begin
                    idx_d    = idx_q + 4'd1;
                    estado_d = CARGA;
                end else begin
                    estado_d = FIN;
                end
            end
            FIN: estado_d = REPOSO;
`ifdef SEQ_TIMEOUT_EN
            ABORTA: estado_d = REPOSO;
`endif
            default: estado_d = REPOSO;
        endcase
    end

    // Local index to RTC register address map.
    always_comb begin
        dir_sel = '0;
        case (idx_d)
            4'd0: dir_sel = 8'h21;
            4'd1: dir_sel = 8'h22;
            4'd2: dir_sel = 8'h23;
            4'd3: dir_sel = 8'h24;
            4'd4: dir_sel = 8'h25;
            4'd5: dir_sel = 8'h26;
            4'd6: dir_sel = 8'h27;
            4'd7: dir_sel = 8'h41;
            4'd8: dir_sel = 8'h42;
            4'd9: dir_sel = 8'h43;
            default: dir_sel = '0;
        endcase
    end

    // Write data mux over the local registers.
    always_comb begin
        dato_sel = '0;
        case (idx_d)
            4'd0: dato_sel = seg_hora;
            4'd1: dato_sel = min_hora;
            4'd2: dato_sel = hora_hora;
            4'd3: dato_sel = dia_fecha;
            4'd4: dato_sel = mes_fecha;
            4'd5: dato_sel = jahr_fecha;
            4'd6: dato_sel = dia_semana;
            4'd7: dato_sel = seg_timer;
            4'd8: dato_sel = min_timer;
            4'd9: dato_sel = hora_timer;
            default: dato_sel = '0;
        endcase
    end

    assign en_secuencia_d = (estado_d == CARGA)   || (estado_d == SOLICITA) ||
                            (estado_d == ESPERA)  || (estado_d == CAPTURA)  ||
                            (estado_d == SIGUIENTE);

    // State registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q  <= REPOSO;
            idx_q     <= '0;
            ultima_q  <= '0;
            escribe_q <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            idx_q     <= idx_d;
            ultima_q  <= ultima_d;
            escribe_q <= escribe_d;
        end
    end

    // Outputs are decoded from the next state so each one is registered
    // and lines up with the state it belongs to.
    always_ff @(posedge clk) begin
        if (reset) begin
            tr_inicio_q  <= 1'b0;
            tr_escribe_q <= 1'b0;
            dir_rtc_q    <= '0;
            dato_q       <= '0;
            addr_q       <= '1;
            reg_rd_q     <= 1'b1;
            ocupado_q    <= 1'b0;
            fin_q        <= 1'b0;
        end else begin
            tr_inicio_q  <= (estado_d == SOLICITA);
            tr_escribe_q <= en_secuencia_d ? escribe_d : 1'b0;
            dir_rtc_q    <= en_secuencia_d ? dir_sel : 8'h00;
            addr_q       <= en_secuencia_d ? idx_d : 4'hF;
            reg_rd_q     <= !((estado_d == CAPTURA) && !escribe_d);
            ocupado_q    <= en_secuencia_d;
            fin_q        <= (estado_d == FIN);
            // Data is captured once per access so it stays stable until CAPTURA.
            if (estado_d == CARGA) begin
                dato_q <= dato_sel;
            end else if (!en_secuencia_d) begin
                dato_q <= '0;
            end
        end
    end

`ifdef SEQ_TIMEOUT_EN
    // Wait counter: cleared on entry to ESPERA, counts while waiting.
    always_comb begin
        cnt_d = cnt_q;
        if (estado_q == SOLICITA) begin
            cnt_d = '0;
        end else if (estado_q == ESPERA) begin
            cnt_d = cnt_q + 12'd1;
        end
    end

    // Timeout counter and abort pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            error_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            error_q <= (estado_d == ABORTA);
        end
    end

    assign error_tiempo = error_q;
`else
    logic timeout_unused;
    assign timeout_unused = ^TIMEOUT_CICLOS;
    assign error_tiempo   = 1'b0;
`endif

    assign tr_inicio      = tr_inicio_q;
    assign tr_escribe     = tr_escribe_q;
    assign dir_rtc        = dir_rtc_q;
    assign dato_escritura = dato_q;
    assign addr_mem_local = addr_q;
    assign reg_rd         = reg_rd_q;
    assign ocupado        = ocupado_q;
    assign fin            = fin_q;

endmodule
